// File: rtl/pa_pkg.sv
// Shared opcode map, latency defaults and opcode classification for the issue scheduler.
package pa_pkg;

  localparam logic [6:0] OP_MUL = 7'h02;
  localparam logic [6:0] OP_LDB = 7'h10;
  localparam logic [6:0] OP_LDW = 7'h11;
  localparam logic [6:0] OP_STB = 7'h12;
  localparam logic [6:0] OP_STW = 7'h13;

  localparam int LAT_ALU_DEF  = 1;
  localparam int LAT_LONG_DEF = 5;
  localparam int CNT_W        = 3;

  typedef logic [4:0]       reg_addr_t;
  typedef logic [CNT_W-1:0] wb_cnt_t;

  localparam wb_cnt_t   CNT_ZERO = 3'd0;
  localparam wb_cnt_t   CNT_ONE  = 3'd1;
  localparam reg_addr_t REG_ZERO = 5'd0;

  function automatic logic is_long_op(input logic [6:0] op);
    case (op)
      OP_LDB, OP_LDW, OP_STB, OP_STW, OP_MUL: is_long_op = 1'b1;
      default:                                is_long_op = 1'b0;
    endcase
  endfunction

  function automatic logic is_store_op(input logic [6:0] op);
    case (op)
      OP_STB, OP_STW: is_store_op = 1'b1;
      default:        is_store_op = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/issue_scheduler_if.sv
// Decode-to-issue handshake plus writeback and stall status, shared by decoder and scheduler.
interface issue_scheduler_if;
  import pa_pkg::*;

  logic        dec_valid;
  logic [6:0]  dec_op;
  reg_addr_t   dec_addr_a;
  reg_addr_t   dec_addr_b;
  reg_addr_t   dec_addr_d;
  logic        dec_y_sel;
  logic        dec_write;
  logic        dec_ready;
  logic        issue;
  logic        long_start;
  logic        wb_valid;
  reg_addr_t   wb_addr;
  logic [15:0] stall_cnt;

  modport master (
    output dec_valid, dec_op, dec_addr_a, dec_addr_b, dec_addr_d, dec_y_sel, dec_write,
    input  dec_ready, issue, long_start, wb_valid, wb_addr, stall_cnt
  );

  modport slave (
    input  dec_valid, dec_op, dec_addr_a, dec_addr_b, dec_addr_d, dec_y_sel, dec_write,
    output dec_ready, issue, long_start, wb_valid, wb_addr, stall_cnt
  );

endinterface

// File: rtl/issue_scoreboard.sv
// Per-register countdown to writeback for r1..r31, with source/destination lookups,
// writeback-port occupancy probe and the retiring-register decode.
module issue_scoreboard
  import pa_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           load_en_i,
  input  reg_addr_t      load_addr_i,
  input  wb_cnt_t        load_val_i,
  input  reg_addr_t      addr_a_i,
  input  reg_addr_t      addr_b_i,
  input  reg_addr_t      addr_d_i,
  input  logic [CNT_W:0] port_val_i,
  output wb_cnt_t        cnt_a_o,
  output wb_cnt_t        cnt_b_o,
  output wb_cnt_t        cnt_d_o,
  output logic           port_hit_o,
  output logic           wb_valid_o,
  output reg_addr_t      wb_addr_o
);

  wb_cnt_t cnt_q [1:31];
  wb_cnt_t cnt_d [1:31];

  // Next-state: a new issue reloads the counter, otherwise busy counters count down.
  always_comb begin
    for (int r = 1; r < 32; r++) begin
      cnt_d[r] = (load_en_i && (load_addr_i == reg_addr_t'(r))) ? load_val_i :
                 ((cnt_q[r] != CNT_ZERO) ? (cnt_q[r] - CNT_ONE) : CNT_ZERO);
    end
  end

  // Counter array state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 1; r < 32; r++) begin
        cnt_q[r] <= CNT_ZERO;
      end
    end else begin
      for (int r = 1; r < 32; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
    end
  end

  // Lookups; r0 has no entry so its reads stay at zero and it never retires.
  always_comb begin
    cnt_a_o    = CNT_ZERO;
    cnt_b_o    = CNT_ZERO;
    cnt_d_o    = CNT_ZERO;
    port_hit_o = 1'b0;
    wb_valid_o = 1'b0;
    wb_addr_o  = REG_ZERO;
    for (int r = 1; r < 32; r++) begin
      cnt_a_o    = (addr_a_i == reg_addr_t'(r)) ? cnt_q[r] : cnt_a_o;
      cnt_b_o    = (addr_b_i == reg_addr_t'(r)) ? cnt_q[r] : cnt_b_o;
      cnt_d_o    = (addr_d_i == reg_addr_t'(r)) ? cnt_q[r] : cnt_d_o;
      port_hit_o = port_hit_o | ({1'b0, cnt_q[r]} == port_val_i);
      wb_valid_o = wb_valid_o | (cnt_q[r] == CNT_ONE);
      wb_addr_o  = (cnt_q[r] == CNT_ONE) ? reg_addr_t'(r) : wb_addr_o;
    end
  end

endmodule

// File: rtl/issue_scheduler.sv
// In-order issue gate: RAW/WAW/writeback-port/long-unit hazard checks in front of a
// per-register writeback scoreboard, plus a saturating stall counter.
module issue_scheduler
  import pa_pkg::*;
#(
  parameter int LAT_ALU  = LAT_ALU_DEF,
  parameter int LAT_LONG = LAT_LONG_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  issue_scheduler_if.slave  bus_if
);

  localparam wb_cnt_t LAT_ALU_C  = wb_cnt_t'(LAT_ALU);
  localparam wb_cnt_t LAT_LONG_C = wb_cnt_t'(LAT_LONG);

  logic           long_op_s;
  logic           store_op_s;
  wb_cnt_t        lat_s;
  logic [CNT_W:0] port_val_s;
  logic           raw_s;
  logic           waw_s;
  logic           port_s;
  logic           struct_s;
  logic           ready_s;
  logic           issue_s;
  logic           load_en_s;
  wb_cnt_t        cnt_a_s;
  wb_cnt_t        cnt_b_s;
  wb_cnt_t        cnt_d_s;
  logic           port_hit_s;
  logic           wb_valid_s;
  reg_addr_t      wb_addr_s;

  wb_cnt_t        long_cnt_q;
  wb_cnt_t        long_cnt_d;
  logic [15:0]    stall_cnt_q;
  logic [15:0]    stall_cnt_d;

  issue_scoreboard u_scoreboard (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_en_i   (load_en_s),
    .load_addr_i (bus_if.dec_addr_d),
    .load_val_i  (lat_s),
    .addr_a_i    (bus_if.dec_addr_a),
    .addr_b_i    (bus_if.dec_addr_b),
    .addr_d_i    (bus_if.dec_addr_d),
    .port_val_i  (port_val_s),
    .cnt_a_o     (cnt_a_s),
    .cnt_b_o     (cnt_b_s),
    .cnt_d_o     (cnt_d_s),
    .port_hit_o  (port_hit_s),
    .wb_valid_o  (wb_valid_s),
    .wb_addr_o   (wb_addr_s)
  );

  // Hazard evaluation and issue handshake; a counter at 1 retires this cycle and is not a hazard.
  always_comb begin
    long_op_s  = is_long_op(bus_if.dec_op);
    store_op_s = is_store_op(bus_if.dec_op);
    lat_s      = long_op_s ? LAT_LONG_C : LAT_ALU_C;
    // A pending write at L+1 would share the writeback port with this op.
    port_val_s = {1'b0, lat_s} + 4'd1;
    raw_s      = (cnt_a_s > CNT_ONE) || (bus_if.dec_y_sel && (cnt_b_s > CNT_ONE));
    waw_s      = bus_if.dec_write && (cnt_d_s > CNT_ONE);
    port_s     = bus_if.dec_write && port_hit_s;
    struct_s   = long_op_s && (long_cnt_q > CNT_ONE);
    ready_s    = !bus_if.dec_valid || !(raw_s || waw_s || port_s || struct_s);
    issue_s    = bus_if.dec_valid && ready_s && rst_n;
    load_en_s  = issue_s && bus_if.dec_write && !store_op_s && (bus_if.dec_addr_d != REG_ZERO);
    long_cnt_d = (issue_s && long_op_s) ? LAT_LONG_C :
                 ((long_cnt_q != CNT_ZERO) ? (long_cnt_q - CNT_ONE) : CNT_ZERO);
    stall_cnt_d = (bus_if.dec_valid && !ready_s && (stall_cnt_q != 16'hFFFF)) ?
                  (stall_cnt_q + 16'd1) : stall_cnt_q;
  end

  // Long-unit occupancy and stall counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      long_cnt_q  <= CNT_ZERO;
      stall_cnt_q <= 16'd0;
    end else begin
      long_cnt_q  <= long_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus_if.dec_ready  = ready_s;
  assign bus_if.issue      = issue_s;
  assign bus_if.long_start = issue_s && long_op_s;
  assign bus_if.wb_valid   = wb_valid_s;
  assign bus_if.wb_addr    = wb_addr_s;
  assign bus_if.stall_cnt  = stall_cnt_q;

endmodule

// File: doc/issue_scheduler.md
ISSUE_SCHEDULER -- requirements
Module: issue_scheduler

Interface
REQ-001 Parameters SHALL be: LAT_ALU, default 1, ALU writeback latency in cycles; LAT_LONG, default 5, memory/multiply latency in cycles.
REQ-002 clk  input  1  single clock, all state on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 dec_valid  input  1  decoded instruction present.
REQ-005 dec_op  input  7  opcode field.
REQ-006 dec_addr_a / dec_addr_b / dec_addr_d  input  5 each  source A, source B, destination register.
REQ-007 dec_y_sel  input  1  1 = source B register read; 0 = offset used, B not read.
REQ-008 dec_write  input  1  instruction writes addr_d.
REQ-009 dec_ready  output  1  combinational; instruction may issue this cycle.
REQ-010 issue  output  1  dec_valid & dec_ready.
REQ-011 long_start  output  1  pulse, long-unit (load/store/mul) op issued this cycle.
REQ-012 wb_valid / wb_addr  output  1 / 5  register-file write occurs this cycle to wb_addr.
REQ-013 stall_cnt  output  16  saturating count of cycles with dec_valid & !dec_ready.

Function
REQ-014 Long ops SHALL be OP_LDB 7'h10, OP_LDW 7'h11, OP_STB 7'h12, OP_STW 7'h13, OP_MUL 7'h02; all others ALU; L = LAT_LONG or LAT_ALU accordingly.
REQ-015 Per register r1..r31 a 3-bit counter cnt[r] SHALL hold remaining cycles to writeback; 0 = idle.
REQ-016 On issue with dec_write=1 and addr_d!=0, cnt[addr_d] SHALL load L at the clock edge; nonzero counters decrement by 1 each edge otherwise.
REQ-017 wb_valid SHALL be 1 with wb_addr=r in any cycle where cnt[r]==1; at most one such r exists (guaranteed by REQ-020).
REQ-018 RAW: dec_ready SHALL be 0 if cnt[addr_a]>1, or dec_y_sel=1 and cnt[addr_b]>1; cnt==1 is not a hazard (write-through register file).
REQ-019 WAW: dec_ready SHALL be 0 if dec_write=1 and cnt[addr_d]>1.
REQ-020 Writeback port: dec_ready SHALL be 0 if dec_write=1 and any cnt[r]==L+1 (new op would retire in same cycle as a pending one).
REQ-021 Structural: long unit non-pipelined; counter long_cnt loads LAT_LONG on long issue, decrements to 0; dec_ready SHALL be 0 for a long op while long_cnt>1.
REQ-022 Stores occupy the long unit but set no cnt and produce no wb_valid.
REQ-023 Register r0: never busy, never hazard, writes to r0 produce no wb_valid.
REQ-024 Issue to addr_d in the same cycle cnt[addr_d]==1: the old write retires (wb_valid this cycle); new load of L wins at the edge.
REQ-025 dec_ready SHALL be 1 when dec_valid=0 (don't-care issue suppressed by issue=0); dec_ready SHALL NOT depend on issue.
REQ-026 stall_cnt SHALL saturate at 16'hFFFF.
REQ-027 Issue-to-writeback latency SHALL be exactly L cycles: issue in cycle T gives wb_valid in cycle T+L.

Reset
REQ-028 rst_n=0 SHALL asynchronously clear all cnt, long_cnt, stall_cnt; outputs wb_valid=0, long_start=0, issue=0, stall_cnt=0; dec_ready=1.
REQ-029 Reset mid-operation SHALL discard all pending writebacks; no wb_valid after release for pre-reset issues.

Structure
REQ-030 Opcode constants, LAT defaults and long-op classification function SHALL live in shared package pa_pkg.
REQ-031 The 31-entry counter array with wb/hazard lookups SHALL be sub-module issue_scoreboard; hazard and handshake logic stays in issue_scheduler.

Verification
REQ-032 ALU r1<=.. at T, dependent ALU reading r1 at T+1 -> no stall, wb_valid r1 at T+1.
REQ-033 LDW r2 at T, ALU reading r2 -> dec_ready=0 T+1..T+4, issues T+5, stall_cnt=4.
REQ-034 LDW r3 at T, ALU r4 (independent) offered T+4 -> stalled one cycle (port conflict at T+5), issues T+5, wb r3 T+5, wb r4 T+6.
REQ-035 MUL r5 at T, STW at T+1 -> stalled until T+5, long_start at T and T+5, no wb_valid for store.
REQ-036 ALU write r0, then read r0 -> no wb_valid, no stall.
REQ-037 LDW r6 at T, rst_n low at T+2 for one cycle -> all cnt 0, dec_ready=1, no wb_valid at T+5.
